// File: rtl/io_pkg.sv
// Shared definitions for the CPU-bus to RAM stream controller: FSM encoding,
// header field layout and the beats-per-word helper.
package io_pkg;

   // Header beat layout: base address in the low bits, word count just above it.
   localparam int unsigned HDR_BASE_LSB = 0;

   // FSM encoding, kept as plain constants for compatibility with older tools.
   localparam logic [3:0] StIdle    = 4'd0;
   localparam logic [3:0] StHdrDone = 4'd1;
   localparam logic [3:0] StRecv    = 4'd2;
   localparam logic [3:0] StWrite   = 4'd3;
   localparam logic [3:0] StLdone   = 4'd4;
   localparam logic [3:0] StSread   = 4'd5;
   localparam logic [3:0] StSwait   = 4'd6;
   localparam logic [3:0] StSbeat   = 4'd7;
   localparam logic [3:0] StSdone   = 4'd8;

   // Count field sits directly above the base address field.
   function automatic int unsigned hdr_cnt_lsb(input int unsigned addr_width);
      return addr_width;
   endfunction

   // Number of bus beats that make up one RAM word.
   function automatic int unsigned beats(input int unsigned data_width,
                                         input int unsigned bus_width);
      return data_width / bus_width;
   endfunction

endpackage

// File: rtl/io_stream_controller_if.sv
// Control, handshake and RAM-side signals of the stream controller.
// The tri-state CPU data bus stays a plain inout on the controller itself.
interface io_stream_controller_if #(
   parameter int unsigned ADDRESS_WIDTH = 13,
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned COUNT_WIDTH   = 12
);
   logic                     INT;
   logic                     Load_Process;
   logic                     Send_Start;
   logic [ADDRESS_WIDTH-1:0] Send_Base;
   logic [COUNT_WIDTH-1:0]   Send_Count;
   logic                     Bus_Valid;
   logic                     Bus_Ack;
   logic                     Busy;
   logic                     Done_Loading;
   logic                     Done_Processing_Current_Packet;
   logic                     Done_Sending;
   logic                     Abort;
   logic                     Wrap;
   logic                     IO_Memory_WR_Enable;
   logic [ADDRESS_WIDTH-1:0] RAM_Address_WR;
   logic [DATA_WIDTH-1:0]    RAM_Data_WR;
   logic [ADDRESS_WIDTH-1:0] RAM_Address_RD;
   logic [DATA_WIDTH-1:0]    RAM_Data_RD;

   // Controller side.
   modport slave (
      input  INT, Load_Process, Send_Start, Send_Base, Send_Count, Bus_Ack, RAM_Data_RD,
      output Bus_Valid, Busy, Done_Loading, Done_Processing_Current_Packet, Done_Sending,
             Abort, Wrap, IO_Memory_WR_Enable, RAM_Address_WR, RAM_Data_WR, RAM_Address_RD
   );

   // CPU / RAM environment side.
   modport master (
      output INT, Load_Process, Send_Start, Send_Base, Send_Count, Bus_Ack, RAM_Data_RD,
      input  Bus_Valid, Busy, Done_Loading, Done_Processing_Current_Packet, Done_Sending,
             Abort, Wrap, IO_Memory_WR_Enable, RAM_Address_WR, RAM_Data_WR, RAM_Address_RD
   );

endinterface

// File: rtl/io_beat_shifter.sv
// Pack/unpack register between bus beats and RAM words. Beats are placed
// little-endian: beat k occupies bits [k*BusWidth +: BusWidth].
module io_beat_shifter
   import io_pkg::*;
#(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned BusWidth  = 32,
   localparam int unsigned Beats    = beats(DataWidth, BusWidth),
   localparam int unsigned IdxWidth = (Beats > 1) ? $clog2(Beats) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clr_i,
   input  logic                 capture_i,
   input  logic [BusWidth-1:0]  beat_i,
   input  logic                 load_i,
   input  logic [DataWidth-1:0] word_i,
   input  logic                 next_i,
   output logic [DataWidth-1:0] word_o,
   output logic [BusWidth-1:0]  beat_o,
   output logic [IdxWidth-1:0]  idx_o
);

   logic [DataWidth-1:0] word_q, word_d;
   logic [IdxWidth-1:0]  idx_q, idx_d;
   logic                 last;

   assign last   = (idx_q == IdxWidth'(Beats - 1));
   assign word_o = word_q;
   assign beat_o = word_q[32'(idx_q) * BusWidth +: BusWidth];
   assign idx_o  = idx_q;

   // Next-state: clear, parallel load (send), or capture/advance one beat.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clr_i) begin
         word_d = '0;
         idx_d  = '0;
      end else if (load_i) begin
         word_d = word_i;
         idx_d  = '0;
      end else begin
         if (capture_i) begin
            word_d[32'(idx_q) * BusWidth +: BusWidth] = beat_i;
         end
         if (capture_i || next_i) begin
            idx_d = last ? '0 : idx_q + 1'b1;
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/io_stream_controller.sv
// Loads framed packets from the CPU bus into RAM and streams RAM regions back
// onto the same bus under a valid/ack handshake.
module io_stream_controller
   import io_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 13,
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned BUS_WIDTH     = 32,
   parameter int unsigned COUNT_WIDTH   = 12
) (
   input  logic                 CLK,
   input  logic                 RST,
   inout  wire [BUS_WIDTH-1:0]  CPU_Bus,
   io_stream_controller_if.slave ctl
);

   localparam int unsigned Beats     = beats(DATA_WIDTH, BUS_WIDTH);
   localparam int unsigned IdxWidth  = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned HdrCntLsb = hdr_cnt_lsb(ADDRESS_WIDTH);

   logic [3:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
   logic                     wrap_q, wrap_d;

   logic                     sh_clr, sh_cap, sh_load, sh_next, sh_last;
   logic [DATA_WIDTH-1:0]    sh_word;
   logic [BUS_WIDTH-1:0]     sh_beat;
   logic [IdxWidth-1:0]      sh_idx;

   assign sh_last = (sh_idx == IdxWidth'(Beats - 1));

   io_beat_shifter #(
      .DataWidth(DATA_WIDTH),
      .BusWidth (BUS_WIDTH)
   ) u_shifter (
      .clk_i    (CLK),
      .rst_i    (RST),
      .clr_i    (sh_clr),
      .capture_i(sh_cap),
      .beat_i   (CPU_Bus),
      .load_i   (sh_load),
      .word_i   (ctl.RAM_Data_RD),
      .next_i   (sh_next),
      .word_o   (sh_word),
      .beat_o   (sh_beat),
      .idx_o    (sh_idx)
   );

   // FSM next-state, address/count bookkeeping and shifter control.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wrap_d  = wrap_q;
      sh_clr  = 1'b0;
      sh_cap  = 1'b0;
      sh_load = 1'b0;
      sh_next = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Load has priority; a coincident Send_Start is dropped.
            if (ctl.INT && ctl.Load_Process) begin
               addr_d  = CPU_Bus[HDR_BASE_LSB +: ADDRESS_WIDTH];
               rem_d   = CPU_Bus[HdrCntLsb +: COUNT_WIDTH];
               wrap_d  = 1'b0;
               sh_clr  = 1'b1;
               state_d = (CPU_Bus[HdrCntLsb +: COUNT_WIDTH] == '0) ? StLdone : StRecv;
            end else if (ctl.Send_Start) begin
               addr_d  = ctl.Send_Base;
               rem_d   = ctl.Send_Count;
               wrap_d  = 1'b0;
               sh_clr  = 1'b1;
               state_d = (ctl.Send_Count == '0) ? StSdone : StSread;
            end
         end
         // Unused encoding: the header is consumed directly from idle.
         StHdrDone: state_d = StRecv;
         StRecv: begin
            if (!ctl.Load_Process) begin
               state_d = StIdle;
            end else if (ctl.INT) begin
               sh_cap = 1'b1;
               if (sh_last) state_d = StWrite;
            end
         end
         StWrite: begin
            if (rem_q == COUNT_WIDTH'(1)) begin
               state_d = StLdone;
            end else begin
               rem_d   = rem_q - 1'b1;
               addr_d  = addr_q + 1'b1;
               wrap_d  = wrap_q | (&addr_q);
               state_d = StRecv;
            end
         end
         StLdone: state_d = StIdle;
         StSread: state_d = StSwait;
         StSwait: begin
            sh_load = 1'b1;
            state_d = StSbeat;
         end
         StSbeat: begin
            if (ctl.Bus_Ack) begin
               sh_next = 1'b1;
               if (sh_last) begin
                  if (rem_q == COUNT_WIDTH'(1)) begin
                     state_d = StSdone;
                  end else begin
                     rem_d   = rem_q - 1'b1;
                     addr_d  = addr_q + 1'b1;
                     wrap_d  = wrap_q | (&addr_q);
                     state_d = StSread;
                  end
               end
            end
         end
         StSdone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rem_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wrap_q  <= wrap_d;
      end
   end

   assign ctl.Busy                           = (state_q != StIdle);
   assign ctl.Done_Loading                   = (state_q == StLdone);
   assign ctl.Done_Processing_Current_Packet = (state_q == StWrite);
   assign ctl.Done_Sending                   = (state_q == StSdone);
   assign ctl.Abort                          = (state_q == StRecv) && !ctl.Load_Process;
   assign ctl.Wrap                           = wrap_q;
   assign ctl.IO_Memory_WR_Enable            = (state_q == StWrite);
   assign ctl.RAM_Address_WR                 = (state_q == StWrite) ? addr_q : '0;
   assign ctl.RAM_Data_WR                    = (state_q == StWrite) ? sh_word : '0;
   assign ctl.RAM_Address_RD                 = (state_q == StSread) ? addr_q : '0;
   assign ctl.Bus_Valid                      = (state_q == StSbeat);

   // The bus is only ever driven while presenting a send beat.
   assign CPU_Bus = (state_q == StSbeat) ? sh_beat : {BUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_io_stream_controller.sv
// Self-checking bench for io_stream_controller: directed scenarios plus
// randomized load/send round trips against a word-level RAM model.
module tb_io_stream_controller;

   localparam int unsigned AW    = 13;
   localparam int unsigned DW    = 64;
   localparam int unsigned BW    = 32;
   localparam int unsigned CW    = 12;
   localparam int unsigned Words = 1 << AW;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   wire  [BW-1:0] bus;
   logic          tb_en  = 1'b0;
   logic [BW-1:0] tb_drv = '0;

   assign bus = tb_en ? tb_drv : {BW{1'bz}};

   io_stream_controller_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) ifc ();

   io_stream_controller #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .BUS_WIDTH    (BW),
      .COUNT_WIDTH  (CW)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .CPU_Bus(bus),
      .ctl    (ifc)
   );

   always #5 CLK = ~CLK;

   // Environment RAM: registered read, writes from DUT or from the init loader.
   logic [DW-1:0] ram [Words];
   logic          init_we = 1'b0;
   logic [AW-1:0] init_addr = '0;
   logic [DW-1:0] init_data = '0;
   always @(posedge CLK) begin
      if (init_we) ram[init_addr] <= init_data;
      else if (ifc.IO_Memory_WR_Enable) ram[ifc.RAM_Address_WR] <= ifc.RAM_Data_WR;
      ifc.RAM_Data_RD <= ram[ifc.RAM_Address_RD];
   end

   // Reference memory image, maintained from what loads are supposed to write.
   logic [DW-1:0] ref_mem [Words];
   logic [DW-1:0] wq [$];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Header, optional coincident Send_Start, then BEATS beats per word with gaps.
   task automatic do_load(input logic [AW-1:0] base, input int cnt, input bit with_send);
      logic [AW-1:0] a;
      logic          ew;
      tb_en             = 1'b1;
      tb_drv            = {7'($urandom), 12'(cnt), base};
      ifc.INT           = 1'b1;
      ifc.Load_Process  = 1'b1;
      ifc.Send_Start    = with_send;
      ifc.Send_Base     = 13'($urandom);
      ifc.Send_Count    = 12'd2;
      tick();
      ifc.Send_Start = 1'b0;
      ifc.INT        = 1'b0;
      ew = (32'(base) + 32'(cnt) > Words);
      if (cnt == 0) begin
         chk("ld0_done", 64'(ifc.Done_Loading), 64'd1);
         chk("ld0_nowr", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
         tick();
         chk("ld0_idle", 64'(ifc.Busy), 64'd0);
         chk("ld0_nowr2", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
         tb_en = 1'b0;
         return;
      end
      for (int w = 0; w < cnt; w++) begin
         for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 2)) begin
               chk("ld_gap_nowr", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
               tick();
            end
            tb_drv  = wq[w][k*32 +: 32];
            ifc.INT = 1'b1;
            if (with_send) begin
               chk("ld_nord", 64'(ifc.RAM_Address_RD), 64'd0);
               chk("ld_novalid", 64'(ifc.Bus_Valid), 64'd0);
            end
            tick();
            ifc.INT = 1'b0;
         end
         a = base + 13'(w);
         chk("ld_wr_en", 64'(ifc.IO_Memory_WR_Enable), 64'd1);
         chk("ld_wr_addr", 64'(ifc.RAM_Address_WR), 64'(a));
         chk("ld_wr_data", ifc.RAM_Data_WR, wq[w]);
         chk("ld_pkt_pulse", 64'(ifc.Done_Processing_Current_Packet), 64'd1);
         chk("ld_not_done", 64'(ifc.Done_Loading), 64'd0);
         ref_mem[a] = wq[w];
         tb_drv = 32'hA5C3_5A3C;
         #1;
         chk("ld_bus_free", 64'(bus), 64'hA5C3_5A3C);
         tick();
      end
      chk("ld_done", 64'(ifc.Done_Loading), 64'd1);
      chk("ld_done_nowr", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
      chk("ld_wrap", 64'(ifc.Wrap), 64'(ew));
      tick();
      chk("ld_idle", 64'(ifc.Busy), 64'd0);
      chk("ld_done_1cyc", 64'(ifc.Done_Loading), 64'd0);
      tb_en = 1'b0;
   endtask

   // Send with per-beat ack delay (dly < 0 picks a random delay per beat).
   task automatic do_send(input logic [AW-1:0] base, input int cnt, input int dly);
      logic [AW-1:0] a;
      logic          ew;
      int            d;
      tb_en          = 1'b0;
      ifc.Send_Start = 1'b1;
      ifc.Send_Base  = base;
      ifc.Send_Count = 12'(cnt);
      tick();
      ifc.Send_Start = 1'b0;
      ew = (32'(base) + 32'(cnt) > Words);
      if (cnt == 0) begin
         chk("sd0_done", 64'(ifc.Done_Sending), 64'd1);
         chk("sd0_novalid", 64'(ifc.Bus_Valid), 64'd0);
         tick();
         chk("sd0_idle", 64'(ifc.Busy), 64'd0);
         return;
      end
      for (int w = 0; w < cnt; w++) begin
         a = base + 13'(w);
         chk("sd_rd_addr", 64'(ifc.RAM_Address_RD), 64'(a));
         chk("sd_rd_novalid", 64'(ifc.Bus_Valid), 64'd0);
         ifc.Bus_Ack = 1'($urandom);
         tick();
         chk("sd_wait_novalid", 64'(ifc.Bus_Valid), 64'd0);
         ifc.Bus_Ack = 1'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            ifc.Bus_Ack = 1'b0;
            for (int j = 0; j < d; j++) begin
               chk("sd_valid_hold", 64'(ifc.Bus_Valid), 64'd1);
               chk("sd_beat_hold", 64'(bus), 64'(ref_mem[a][k*32 +: 32]));
               tick();
            end
            ifc.Bus_Ack = 1'b1;
            chk("sd_valid", 64'(ifc.Bus_Valid), 64'd1);
            chk("sd_beat", 64'(bus), 64'(ref_mem[a][k*32 +: 32]));
            tick();
            ifc.Bus_Ack = 1'b0;
         end
      end
      chk("sd_done", 64'(ifc.Done_Sending), 64'd1);
      chk("sd_wrap", 64'(ifc.Wrap), 64'(ew));
      tick();
      chk("sd_idle", 64'(ifc.Busy), 64'd0);
      chk("sd_done_1cyc", 64'(ifc.Done_Sending), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] b;
      int            n;
      ifc.INT          = 1'b0;
      ifc.Load_Process = 1'b0;
      ifc.Send_Start   = 1'b0;
      ifc.Send_Base    = '0;
      ifc.Send_Count   = '0;
      ifc.Bus_Ack      = 1'b0;

      // Preload RAM and reference with the same random image while in reset.
      for (int i = 0; i < int'(Words); i++) ref_mem[i] = {$urandom, $urandom};
      #1;
      init_we = 1'b1;
      for (int i = 0; i < int'(Words); i++) begin
         init_addr = 13'(i);
         init_data = ref_mem[i];
         tick();
      end
      init_we = 1'b0;
      tick();
      RST = 1'b0;

      // Reset state.
      chk("rst_busy", 64'(ifc.Busy), 64'd0);
      chk("rst_valid", 64'(ifc.Bus_Valid), 64'd0);
      chk("rst_wr", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
      chk("rst_wrap", 64'(ifc.Wrap), 64'd0);
      chk("rst_dl", 64'(ifc.Done_Loading), 64'd0);
      chk("rst_ds", 64'(ifc.Done_Sending), 64'd0);
      chk("rst_abort", 64'(ifc.Abort), 64'd0);
      chk("rst_rdaddr", 64'(ifc.RAM_Address_RD), 64'd0);
      tb_en  = 1'b1;
      tb_drv = 32'h5A5A_0F0F;
      #1;
      chk("rst_bus_hiz", 64'(bus), 64'h5A5A_0F0F);
      tb_en = 1'b0;

      // Two-word load at 0x010, then read it back with zero ack delay.
      wq = '{64'h2222_2222_1111_1111, 64'h4444_4444_3333_3333};
      do_load(13'h010, 2, 1'b0);
      do_send(13'h010, 2, 0);

      // Empty packet.
      do_load(13'h123, 0, 1'b0);

      // Send across the top of the address space with slow acks.
      do_send(13'h1FFF, 2, 3);

      // Abort mid-packet, then a normal packet.
      tb_en            = 1'b1;
      tb_drv           = {7'd0, 12'd1, 13'h0400};
      ifc.INT          = 1'b1;
      ifc.Load_Process = 1'b1;
      tick();
      tb_drv = 32'hDEAD_BEEF;
      tick();
      ifc.INT          = 1'b0;
      ifc.Load_Process = 1'b0;
      #1;
      chk("ab_pulse", 64'(ifc.Abort), 64'd1);
      chk("ab_nowr", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
      tick();
      chk("ab_1cyc", 64'(ifc.Abort), 64'd0);
      chk("ab_idle", 64'(ifc.Busy), 64'd0);
      chk("ab_nowr2", 64'(ifc.IO_Memory_WR_Enable), 64'd0);
      wq = '{{$urandom, $urandom}};
      do_load(13'h0400, 1, 1'b0);
      do_send(13'h0400, 1, 1);

      // Load and Send_Start in the same cycle: load wins, send dropped.
      wq = '{{$urandom, $urandom}, {$urandom, $urandom}};
      do_load(13'h0777, 2, 1'b1);
      ifc.Load_Process = 1'b0;
      repeat (3) begin
         chk("coll_no_send", 64'(ifc.Busy), 64'd0);
         chk("coll_no_rd", 64'(ifc.RAM_Address_RD), 64'd0);
         tick();
      end

      // Reset while presenting a beat.
      ifc.Send_Start = 1'b1;
      ifc.Send_Base  = 13'h0055;
      ifc.Send_Count = 12'd1;
      tick();
      ifc.Send_Start = 1'b0;
      tick();
      tick();
      chk("rsb_valid", 64'(ifc.Bus_Valid), 64'd1);
      RST = 1'b1;
      tick();
      chk("rsb_valid_off", 64'(ifc.Bus_Valid), 64'd0);
      chk("rsb_idle", 64'(ifc.Busy), 64'd0);
      tb_en  = 1'b1;
      tb_drv = 32'h3C3C_C3C3;
      #1;
      chk("rsb_bus_hiz", 64'(bus), 64'h3C3C_C3C3);
      RST   = 1'b0;
      tb_en = 1'b0;
      repeat (5) begin
         chk("rsb_no_done", 64'(ifc.Done_Sending), 64'd0);
         tick();
      end

      // Randomized load/readback round trips, some crossing the wrap point.
      for (int i = 0; i < 6; i++) begin
         b = ($urandom_range(0, 2) == 0) ? 13'h1FFE : 13'($urandom);
         n = $urandom_range(1, 3);
         wq.delete();
         repeat (n) wq.push_back({$urandom, $urandom});
         do_load(b, n, 1'b0);
         ifc.Load_Process = 1'($urandom);
         do_send(b, n, -1);
         ifc.Load_Process = 1'b0;
      end

      // Randomized sends of arbitrary regions, including empty ones.
      for (int i = 0; i < 6; i++) begin
         do_send(13'($urandom), $urandom_range(0, 3), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_stream_controller.md
Name: io_stream_controller

Overview:
Parametrised successor of the CPU-to-RAM I/O block. Receives framed packets from the shared tri-state CPU bus, assembles bus beats into RAM words and writes them at a header-specified base address. On request, reads a RAM region back and serialises it onto the same bus under a valid/ack handshake. Sits between the CPU bus and the solver RAM, and owns all RAM write traffic plus I/O read traffic.

Parameters:
ADDRESS_WIDTH, 13, RAM word-address width
DATA_WIDTH, 64, RAM word width; integer multiple of BUS_WIDTH
BUS_WIDTH, 32, CPU bus width
COUNT_WIDTH, 12, packet word-count width; COUNT_WIDTH+ADDRESS_WIDTH <= BUS_WIDTH

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
INT  in  1  CPU beat strobe for loading
Load_Process  in  1  load mode select; a beat is captured when INT && Load_Process
Send_Start  in  1  one-cycle send request
Send_Base  in  ADDRESS_WIDTH  first RAM address to send
Send_Count  in  COUNT_WIDTH  words to send
CPU_Bus  inout  BUS_WIDTH  shared bus; driven only in the send-beat state, else high-Z
Bus_Valid  out  1  driven beat valid
Bus_Ack  in  1  CPU accepted the beat
Busy  out  1  FSM not IDLE
Done_Loading  out  1  one-cycle pulse: packet fully written
Done_Processing_Current_Packet  out  1  one-cycle pulse per RAM word written
Done_Sending  out  1  one-cycle pulse: send complete
Abort  out  1  one-cycle pulse: load aborted
Wrap  out  1  sticky; address wrapped past 2^ADDRESS_WIDTH-1; cleared by RST or a new start
IO_Memory_WR_Enable  out  1  RAM write strobe
RAM_Address_WR  out  ADDRESS_WIDTH  RAM write address
RAM_Data_WR  out  DATA_WIDTH  RAM write data
RAM_Address_RD  out  ADDRESS_WIDTH  RAM read address
RAM_Data_RD  in  DATA_WIDTH  RAM read data, valid 1 cycle after address (registered read)

Behaviour:
- Reset: all outputs 0, Wrap 0, CPU_Bus high-Z, FSM IDLE, beat counter 0, assembly register 0. Reset mid-operation discards all partial state and releases the bus on the next edge.
- BEATS = DATA_WIDTH/BUS_WIDTH. Beat k fills bits [k*BUS_WIDTH +: BUS_WIDTH] (little-endian).
- States: IDLE, HDR_DONE, RECV, WRITE, LDONE, SREAD, SWAIT, SBEAT, SDONE.
- IDLE: capture on INT && Load_Process. Header = beat 0: base = bus[ADDRESS_WIDTH-1:0], count = bus[ADDRESS_WIDTH +: COUNT_WIDTH]. Go to RECV, or to LDONE if count = 0. Otherwise Send_Start goes to SREAD, or to SDONE if Send_Count = 0. If both occur in the same cycle, load wins and Send_Start is dropped, not queued.
- RECV: each strobed beat is stored and the beat counter advanced. After beat BEATS-1 go to WRITE. Cycles with INT low hold state.
- WRITE: one cycle. IO_Memory_WR_Enable=1, address = base+word_idx mod 2^ADDRESS_WIDTH, and Done_Processing_Current_Packet pulses. The last word goes to LDONE, otherwise back to RECV.
- LDONE: Done_Loading pulses for 1 cycle, then IDLE.
- Load_Process low in RECV: no write, Abort pulses, go to IDLE. Words already written stay written.
- SREAD: drive RAM_Address_RD for 1 cycle, then SWAIT latches RAM_Data_RD into the shift register.
- SBEAT: drive the current beat onto CPU_Bus with Bus_Valid=1, held stable until Bus_Ack is sampled high. On ack: advance to the next beat, go to SREAD for the next word, or go to SDONE after the final beat.
- SDONE: Done_Sending pulses for 1 cycle, then IDLE. Bus_Ack outside SBEAT is ignored.
- INT during a send is ignored. Send_Start during a load is ignored.
- Addresses wrap modulo 2^ADDRESS_WIDTH. Wrap is set on the first wrapped access.
- Throughput: load takes BEATS strobed cycles + 1 write cycle per word. Send takes 2 + BEATS cycles per word at zero ack delay.

Decomposition:
- Shared package io_pkg holds the FSM state encoding, BEATS, and the header field offsets (HDR_BASE_LSB=0, HDR_CNT_LSB=ADDRESS_WIDTH).
- One sub-module, io_beat_shifter: BUS_WIDTH/DATA_WIDTH pack-unpack register with load, shift and beat-index outputs, used by both directions.

Test Plan:
- Load with header base=0x010, count=2, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444: writes 0x2222222211111111 at 0x010 and 0x4444444433333333 at 0x011, two packet pulses, Done_Loading in the cycle after the 2nd write.
- Header with count=0: Done_Loading one cycle after the header, no IO_Memory_WR_Enable, Busy back to 0.
- Send_Base=0x1FFF, Send_Count=2, Bus_Ack delayed 3 cycles per beat: reads 0x1FFF then 0x0000, Wrap=1, each beat stable on CPU_Bus until ack, low half first, Done_Sending after the 4th ack.
- Load header count=1, one data beat, then Load_Process low: Abort pulses, no write, next header accepted normally.
- Send_Start in the same cycle as the first INT && Load_Process: load proceeds, no RAM_Address_RD activity, bus never driven.
- RST asserted in SBEAT: CPU_Bus high-Z and Bus_Valid=0 after the next edge, Done_Sending never pulses.
